// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory handshake, redirect input and decode-facing output.
// master = fetch unit, slave = memory/decode side.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem reads, small fetch queue to decode,
// and redirect with flush of queued and in-flight words.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master bus
);

  localparam int             AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [AW-1:0]  PTR_ONE = AW'(1);
  localparam logic [AW:0]    CNT_ONE = (AW + 1)'(1);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_WAIT  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          discard_q, discard_d;
  logic          run_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]   fifo_instr_q [FIFO_DEPTH];

  logic          req_s;
  logic          gnt_s;
  logic          push_s;
  logic          pop_s;
  logic          empty_s;

  // run_q keeps the request low while reset is asserted and for the release cycle.
  assign empty_s = (count_q == '0);
  assign req_s   = run_q && (state_q == S_FETCH) && (count_q < DEPTH_C);
  assign gnt_s   = req_s && bus.imem_gnt;
  assign pop_s   = !empty_s && bus.out_ready && !bus.redirect_valid;

  assign bus.imem_req  = req_s;
  assign bus.imem_addr = pc_q;
  assign bus.out_valid = !empty_s;
  assign bus.out_instr = empty_s ? 32'h0000_0013 : fifo_instr_q[rd_ptr_q];
  assign bus.out_pc    = empty_s ? 32'h0000_0000 : fifo_pc_q[rd_ptr_q];

  // Fetch FSM next state; a redirect in WAIT with a same-cycle response retires that read.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    discard_d = discard_q;
    push_s    = 1'b0;
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc & ~32'h0000_0003;
      if ((state_q == S_WAIT) && bus.imem_rvalid) begin
        state_d   = S_FETCH;
        discard_d = 1'b0;
      end else if ((state_q == S_WAIT) || gnt_s) begin
        state_d   = S_WAIT;
        discard_d = 1'b1;
      end else begin
        state_d   = S_FETCH;
        discard_d = 1'b0;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (gnt_s) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
            state_d  = S_WAIT;
          end else begin
            state_d  = S_FETCH;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            push_s    = !discard_q;
            discard_d = 1'b0;
            state_d   = S_FETCH;
          end else begin
            state_d   = S_WAIT;
          end
        end
        default: begin
          state_d   = S_FETCH;
          discard_d = 1'b0;
        end
      endcase
    end
  end

  // Queue pointer/occupancy update; redirect flushes and overrides any pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      req_pc_q  <= RESET_PC;
      discard_q <= 1'b0;
      run_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      discard_q <= discard_d;
      run_q     <= 1'b1;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Queue storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_q[i]    <= 32'h0000_0000;
        fifo_instr_q[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      fifo_pc_q[wr_ptr_q]    <= req_pc_q;
      fifo_instr_q[wr_ptr_q] <= bus.imem_rdata;
    end
  end

endmodule
